// File: rtl/motor_safety_interlock_pkg.sv
// Shared types and helpers for the motor safety interlock: FSM state encoding,
// angle/duty types and a saturating 12-bit absolute value.
package motor_safety_pkg;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    TRIP  = 2'd1,
    HOLD  = 2'd2,
    RAMP  = 2'd3
  } interlock_state_t;

  typedef logic signed [11:0] angle_t;
  typedef logic [11:0]        duty_t;

  localparam duty_t  DUTY_MAX  = '1;
  localparam angle_t ANGLE_MIN = 12'sh800;

  // -2048 has no positive 12-bit twin; clamp it to the largest magnitude.
  function automatic duty_t abs_sat(input angle_t a);
    if (a == ANGLE_MIN) return duty_t'(12'd2047);
    else if (a[11])     return duty_t'(-a);
    else                return duty_t'(a);
  endfunction

endpackage

// File: rtl/motor_safety_interlock_tick.sv
// Free-running millisecond strobe: one-cycle pulse every CLK_PER_MS clocks,
// cleared only by reset.
module ms_tick_gen #(
  parameter int unsigned CLK_PER_MS = 50000
) (
  input  logic c50m,
  input  logic rst_n,
  output logic ms_tick
);

  localparam int unsigned CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    ms_tick = (cnt_q == LAST);
    cnt_d   = ms_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge c50m or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/motor_safety_interlock.sv
// Final duty gate ahead of the PWM generator: zeroes drive on tilt or brake,
// re-qualifies for HOLD_MS of clean conditions, then soft-ramps back in.
module motor_safety_interlock
  import motor_safety_pkg::*;
#(
  parameter int unsigned CLK_PER_MS  = 50000,
  parameter int unsigned TRIP_ANGLE  = 450,
  parameter int unsigned CLEAR_ANGLE = 350,
  parameter int unsigned HOLD_MS     = 500,
  parameter int unsigned RAMP_STEP   = 16
) (
  input  logic        c50m,
  input  logic        rst_n,
  input  logic [11:0] MotorSignal,
  input  logic [11:0] ResolvedRoll,
  input  logic [11:0] ResolvedPitch,
  input  logic        Brake,
  output logic [11:0] MotorSignalSafety,
  output logic        TiltFault,
  output logic        BrakeFault,
  output logic [1:0]  InterlockState
);

  localparam int unsigned   HW        = $clog2(HOLD_MS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);
  localparam duty_t         TRIP_TH   = duty_t'(TRIP_ANGLE);
  localparam duty_t         CLEAR_TH  = duty_t'(CLEAR_ANGLE);
  localparam logic [12:0]   STEP13    = 13'(RAMP_STEP);

  interlock_state_t state_q, state_d;
  duty_t            out_q, out_d;
  duty_t            ramp_q, ramp_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             tilt_f_q, tilt_f_d;
  logic             brake_f_q, brake_f_d;
  logic             brake_meta_q, brake_sync_q;

  logic        ms_tick;
  duty_t       roll_abs, pitch_abs;
  logic        tilt, clear, fault;
  logic [12:0] ramp_sum;

  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .c50m    (c50m),
    .rst_n   (rst_n),
    .ms_tick (ms_tick)
  );

  assign roll_abs  = abs_sat(angle_t'(ResolvedRoll));
  assign pitch_abs = abs_sat(angle_t'(ResolvedPitch));
  assign tilt      = (roll_abs > TRIP_TH) || (pitch_abs > TRIP_TH);
  assign clear     = (roll_abs < CLEAR_TH) && (pitch_abs < CLEAR_TH);
  assign fault     = tilt || brake_sync_q;
  assign ramp_sum  = {1'b0, ramp_q} + STEP13;

  always_comb begin
    state_d   = state_q;
    out_d     = '0;
    ramp_d    = ramp_q;
    hold_d    = hold_q;
    tilt_f_d  = 1'b0;
    brake_f_d = 1'b0;
    case (state_q)
      ARMED: out_d = MotorSignal;
      TRIP: begin
        if (clear && !brake_sync_q) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (!clear) hold_d = '0;
        else if (ms_tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = RAMP;
            ramp_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      RAMP: begin
        if (ramp_q >= MotorSignal) begin
          state_d = ARMED;
          out_d   = MotorSignal;
        end else begin
          out_d = ramp_q;
          if (ms_tick) ramp_d = ramp_sum[12] ? DUTY_MAX : ramp_sum[11:0];
        end
      end
      default: state_d = TRIP;
    endcase
    // A live fault overrides every state's decision; in TRIP this also keeps the flags live.
    if (fault) begin
      state_d   = TRIP;
      out_d     = '0;
      tilt_f_d  = tilt;
      brake_f_d = brake_sync_q;
    end
  end

  always_ff @(posedge c50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TRIP;
      out_q        <= '0;
      ramp_q       <= '0;
      hold_q       <= '0;
      tilt_f_q     <= 1'b0;
      brake_f_q    <= 1'b0;
      brake_meta_q <= 1'b0;
      brake_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      ramp_q       <= ramp_d;
      hold_q       <= hold_d;
      tilt_f_q     <= tilt_f_d;
      brake_f_q    <= brake_f_d;
      brake_meta_q <= Brake;
      brake_sync_q <= brake_meta_q;
    end
  end

  assign MotorSignalSafety = out_q;
  assign TiltFault         = tilt_f_q;
  assign BrakeFault        = brake_f_q;
  assign InterlockState    = state_q;

endmodule

// File: tb/tb_motor_safety_interlock.sv
// Bench for motor_safety_interlock: directed scenarios with literal expectations
// plus randomized episodes checked every cycle against a behavioural model.
module tb_motor_safety_interlock;

  localparam int CPM   = 8;
  localparam int HOLD  = 20;
  localparam int STEP  = 16;
  localparam int TRIPA = 450;
  localparam int CLRA  = 350;
  localparam int BUDGET = (HOLD + 4096 / STEP + 10) * CPM * 2;

  logic        c50m = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] MotorSignal = '0;
  logic [11:0] ResolvedRoll = '0;
  logic [11:0] ResolvedPitch = '0;
  logic        Brake = 1'b0;
  logic [11:0] MotorSignalSafety;
  logic        TiltFault, BrakeFault;
  logic [1:0]  InterlockState;

  int tests = 0;
  int fails = 0;

  motor_safety_interlock #(
    .CLK_PER_MS  (CPM),
    .TRIP_ANGLE  (TRIPA),
    .CLEAR_ANGLE (CLRA),
    .HOLD_MS     (HOLD),
    .RAMP_STEP   (STEP)
  ) dut (
    .c50m              (c50m),
    .rst_n             (rst_n),
    .MotorSignal       (MotorSignal),
    .ResolvedRoll      (ResolvedRoll),
    .ResolvedPitch     (ResolvedPitch),
    .Brake             (Brake),
    .MotorSignalSafety (MotorSignalSafety),
    .TiltFault         (TiltFault),
    .BrakeFault        (BrakeFault),
    .InterlockState    (InterlockState)
  );

  always #5 c50m = ~c50m;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d..%0d at %0t", name, got, lo, hi, $time);
    end
  endtask

  // Behavioural model: modes use the externally visible InterlockState numbering.
  int m_mode = 1, m_out = 0, m_held_ms = 0, m_ramp = 0, m_k = 0;
  bit m_tf = 0, m_bf = 0, m_b1 = 0, m_b2 = 0, m_ok = 0;
  bit bs, tick, tilt, clr;
  int r, p, ms;

  function automatic int mag(input logic [11:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > 2047) s = 2047;
    return s;
  endfunction

  always @(posedge c50m) begin
    if (!rst_n) begin
      m_mode = 1; m_out = 0; m_held_ms = 0; m_ramp = 0; m_k = 0;
      m_tf = 0; m_bf = 0; m_b1 = 0; m_b2 = 0; m_ok = 1;
    end else begin
      bs   = m_b2;
      tick = (m_k % CPM) == CPM - 1;
      r    = mag(ResolvedRoll);
      p    = mag(ResolvedPitch);
      ms   = int'(MotorSignal);
      tilt = (r > TRIPA) || (p > TRIPA);
      clr  = (r < CLRA) && (p < CLRA);
      m_b2 = m_b1;
      m_b1 = Brake;
      m_k++;
      if (tilt || bs) begin
        m_mode = 1; m_out = 0; m_tf = tilt; m_bf = bs;
      end else begin
        m_tf = 0; m_bf = 0;
        case (m_mode)
          0: m_out = ms;
          1: begin m_out = 0; if (clr) begin m_mode = 2; m_held_ms = 0; end end
          2: begin
            m_out = 0;
            if (!clr) m_held_ms = 0;
            else if (tick) begin
              m_held_ms++;
              if (m_held_ms == HOLD) begin m_mode = 3; m_ramp = 0; end
            end
          end
          default: begin
            if (m_ramp >= ms) begin m_mode = 0; m_out = ms; end
            else begin
              m_out = (ms < m_ramp) ? ms : m_ramp;
              if (tick) m_ramp = (m_ramp + STEP > 4095) ? 4095 : m_ramp + STEP;
            end
          end
        endcase
      end
    end
  end

  always @(negedge c50m) begin
    if (rst_n && m_ok) begin
      chk("model_out", int'(MotorSignalSafety), m_out);
      chk("model_state", int'(InterlockState), m_mode);
      chk("model_tiltfault", int'(TiltFault), int'(m_tf));
      chk("model_brakefault", int'(BrakeFault), int'(m_bf));
    end
  end

  task automatic wait_state(input int st, output int n);
    n = 0;
    while (int'(InterlockState) != st && n < BUDGET) begin
      @(negedge c50m);
      n++;
    end
    chk("wait_state", int'(InterlockState), st);
  endtask

  function automatic logic [11:0] sgn(input int m);
    int v;
    v = ($urandom_range(0, 1) == 1) ? -m : m;
    return 12'(v);
  endfunction

  int n, len, kind;

  initial begin
    repeat (3) @(negedge c50m);
    rst_n = 1'b1;
    chk("reset_state", int'(InterlockState), 1);
    chk("reset_out", int'(MotorSignalSafety), 0);
    chk("reset_flags", int'({TiltFault, BrakeFault}), 0);

    // Power-up: TRIP->HOLD on the first edge, HOLD ms, then 2000/STEP ms of ramp, +1 edge to arm.
    MotorSignal = 12'd2000;
    wait_state(0, n);
    chk("powerup_cycles", n, (HOLD + 2000 / STEP) * CPM + 1);
    chk("powerup_out", int'(MotorSignalSafety), 2000);

    ResolvedRoll = 12'd450;
    @(negedge c50m);
    chk("roll450_state", int'(InterlockState), 0);
    chk("roll450_out", int'(MotorSignalSafety), 2000);
    ResolvedRoll = 12'd451;
    @(negedge c50m);
    chk("roll451_out", int'(MotorSignalSafety), 0);
    chk("roll451_tilt", int'(TiltFault), 1);
    chk("roll451_state", int'(InterlockState), 1);

    ResolvedRoll = 12'd300;
    @(negedge c50m);
    chk("enter_hold", int'(InterlockState), 2);
    ResolvedRoll = 12'd400;
    repeat (2 * HOLD * CPM) @(negedge c50m);
    chk("band_hold_state", int'(InterlockState), 2);
    chk("band_hold_out", int'(MotorSignalSafety), 0);
    ResolvedRoll = 12'd300;
    wait_state(3, n);
    chk_range("hold_to_ramp", n, (HOLD - 1) * CPM + 1, HOLD * CPM);

    wait_state(0, n);
    Brake = 1'b1;
    repeat (3) @(negedge c50m);
    chk("brake_state", int'(InterlockState), 1);
    chk("brake_flag", int'(BrakeFault), 1);
    chk("brake_tiltflag", int'(TiltFault), 0);
    Brake = 1'b0;
    wait_state(2, n);
    repeat (HOLD * CPM * 4 / 5) @(negedge c50m);
    chk("hold_400ms", int'(InterlockState), 2);
    Brake = 1'b1;
    repeat (3) @(negedge c50m);
    chk("brake_in_hold", int'(InterlockState), 1);
    chk("brake_in_hold_flag", int'(BrakeFault), 1);
    Brake = 1'b0;
    wait_state(2, n);
    wait_state(3, n);
    chk_range("hold_restart", n, (HOLD - 1) * CPM + 1, HOLD * CPM);

    wait_state(0, n);
    ResolvedPitch = 12'h800;
    @(negedge c50m);
    chk("pitch_min_tilt", int'(TiltFault), 1);
    chk("pitch_min_out", int'(MotorSignalSafety), 0);
    ResolvedPitch = '0;
    wait_state(0, n);
    ResolvedRoll = 12'(-451);
    @(negedge c50m);
    chk("roll_neg_tilt", int'(TiltFault), 1);
    chk("roll_neg_state", int'(InterlockState), 1);
    ResolvedRoll = '0;

    MotorSignal = 12'd4000;
    wait_state(3, n);
    n = 0;
    while (int'(MotorSignalSafety) < 800 && n < BUDGET) begin @(negedge c50m); n++; end
    chk("ramp_reach_800", int'(MotorSignalSafety >= 12'd800), 1);
    MotorSignal = 12'd300;
    @(negedge c50m);
    chk("ramp_drop_out", int'(MotorSignalSafety), 300);
    chk("ramp_drop_state", int'(InterlockState), 0);
    MotorSignal = 12'd4000;
    ResolvedRoll = 12'd451;
    @(negedge c50m);
    ResolvedRoll = '0;
    wait_state(3, n);
    repeat (60) @(negedge c50m);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", int'(MotorSignalSafety), 0);
    chk("async_rst_state", int'(InterlockState), 1);
    @(negedge c50m);
    rst_n = 1'b1;

    for (int ep = 0; ep < 80; ep++) begin
      kind = int'($urandom_range(0, 99));
      Brake = 1'b0;
      if (kind < 55) begin
        ResolvedRoll  = sgn(int'($urandom_range(0, CLRA - 1)));
        ResolvedPitch = sgn(int'($urandom_range(0, CLRA - 1)));
        len = int'($urandom_range(20, HOLD * CPM * 3));
      end else if (kind < 70) begin
        ResolvedRoll  = sgn(int'($urandom_range(CLRA, TRIPA)));
        ResolvedPitch = sgn(int'($urandom_range(0, TRIPA)));
        len = int'($urandom_range(5, 100));
      end else if (kind < 85) begin
        ResolvedRoll  = sgn(int'($urandom_range(0, 200)));
        ResolvedPitch = ($urandom_range(0, 3) == 0) ? 12'h800 : sgn(int'($urandom_range(TRIPA + 1, 2047)));
        if ($urandom_range(0, 1) == 1) begin
          ResolvedRoll  = ResolvedPitch;
          ResolvedPitch = '0;
        end
        Brake = ($urandom_range(0, 3) == 0);
        len = int'($urandom_range(1, 30));
      end else begin
        Brake = 1'b1;
        len = int'($urandom_range(1, 20));
      end
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: MotorSignal = '0;
          1: MotorSignal = 12'($urandom_range(1, 100));
          default: MotorSignal = 12'($urandom_range(0, 4095));
        endcase
      end
      for (int c = 0; c < len; c++) begin
        @(negedge c50m);
        if ($urandom_range(0, 199) == 0) MotorSignal = 12'($urandom_range(0, 4095));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
